// File: rtl/data_memory_ctrl.sv
// Byte-addressable 32-bit data memory with a valid/ready request/response handshake,
// B/H/W loads and stores, and sign or zero extension of loaded data.
// Define DMEM_SPLIT_ACCESS_EN to execute word-crossing accesses as two word accesses;
// without it, word-crossing accesses return an error.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_ctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] ONE_L   = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef DMEM_SPLIT_ACCESS_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd3} state_t;
`endif

    // Extend a right-aligned load value according to the access control code.
    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] c);
        logic [31:0] r;
        case (c)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b010:  r = d;
            3'b100:  r = {24'h000000, d[7:0]};
            3'b101:  r = {16'h0000, d[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Byte-lane mask of an access before shifting by the address offset.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    state_t            state_r, state_n;
    logic              we_r, err_r;
    logic [2:0]        ctrl_r;
    logic [1:0]        off_r;
    logic [IW-1:0]     idx_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [IW-1:0]     mem_idx_s;
    logic              mem_we_s;
    logic [3:0]        mem_be_s;
    logic [31:0]       mem_wd_s;
    logic [31:0]       rd_s;

    logic              acc_s, cross_s, illegal_s, err_s;
    logic [ADDR_W-1:0] idx_ext_s;
    logic [4:0]        sh_s;
    logic [3:0]        be_lo_s;
    logic [31:0]       wd_lo_s;

    assign acc_s     = req_valid && (state_r == IDLE);
    assign idx_ext_s = {2'b00, req_addr[ADDR_W-1:2]};
    assign sh_s      = {off_r, 3'b000};
    assign rd_s      = mem[mem_idx_s];

`ifdef DMEM_SPLIT_ACCESS_EN
    logic              cross_r;
    logic [31:0]       lo_r;
    logic [7:0]        be8_s;
    logic [63:0]       wd64_s;
    assign be8_s   = {4'b0000, size_mask(ctrl_r[1:0])} << off_r;
    assign wd64_s  = {32'h0000_0000, wdata_r} << sh_s;
    assign be_lo_s = be8_s[3:0];
    assign wd_lo_s = wd64_s[31:0];
`else
    assign be_lo_s = size_mask(ctrl_r[1:0]) << off_r;
    assign wd_lo_s = wdata_r << sh_s;
`endif

    // Classify the presented request: word-crossing and rejection conditions.
    always_comb begin
        cross_s   = 1'b0;
        illegal_s = 1'b0;
        err_s     = 1'b0;
        case (req_ctrl[1:0])
            2'b01:   cross_s = (req_addr[1:0] == 2'b11);
            2'b10:   cross_s = (req_addr[1:0] != 2'b00);
            default: cross_s = 1'b0;
        endcase
        if ((req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
        if (illegal_s || (req_we && req_ctrl[2]) || (idx_ext_s >= DEPTH_L)) begin
            err_s = 1'b1;
        end else if (cross_s && ((idx_ext_s + ONE_L) >= DEPTH_L)) begin
            err_s = 1'b1;
`ifndef DMEM_SPLIT_ACCESS_EN
        end else if (cross_s) begin
            err_s = 1'b1;
`endif
        end else begin
            err_s = 1'b0;
        end
    end

    // Next-state and memory port control.
    always_comb begin
        state_n   = state_r;
        mem_we_s  = 1'b0;
        mem_be_s  = 4'b0000;
        mem_wd_s  = 32'h0000_0000;
        mem_idx_s = idx_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_n = ACCESS;
                end else begin
                    state_n = IDLE;
                end
            end
            ACCESS: begin
                mem_we_s = we_r && !err_r;
                mem_be_s = be_lo_s;
                mem_wd_s = wd_lo_s;
`ifdef DMEM_SPLIT_ACCESS_EN
                if (!err_r && cross_r) begin
                    state_n = SPLIT;
                end else begin
                    state_n = RESP;
                end
`else
                state_n = RESP;
`endif
            end
`ifdef DMEM_SPLIT_ACCESS_EN
            SPLIT: begin
                mem_idx_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                mem_we_s  = we_r;
                mem_be_s  = be8_s[7:4];
                mem_wd_s  = wd64_s[63:32];
                state_n   = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Storage array; not reset, and a write only commits with reset released.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_s[b]) begin
                    mem[mem_idx_s][b*8 +: 8] <= mem_wd_s[b*8 +: 8];
                end
            end
        end
    end

    // Request capture and response data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r        <= 1'b0;
            err_r       <= 1'b0;
            ctrl_r      <= 3'b000;
            off_r       <= 2'b00;
            idx_r       <= '0;
            wdata_r     <= 32'h0000_0000;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
`ifdef DMEM_SPLIT_ACCESS_EN
            cross_r     <= 1'b0;
            lo_r        <= 32'h0000_0000;
`endif
        end else begin
            if (acc_s) begin
                we_r    <= req_we;
                err_r   <= err_s;
                ctrl_r  <= req_ctrl;
                off_r   <= req_addr[1:0];
                idx_r   <= req_addr[IW+1:2];
                wdata_r <= req_wdata;
`ifdef DMEM_SPLIT_ACCESS_EN
                cross_r <= cross_s;
`endif
            end
            case (state_r)
                ACCESS: begin
                    if (err_r) begin
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= we_r ? 32'h0000_0000 : load_ext(rd_s >> sh_s, ctrl_r);
`ifdef DMEM_SPLIT_ACCESS_EN
                        lo_r        <= rd_s;
`endif
                    end
                end
`ifdef DMEM_SPLIT_ACCESS_EN
                SPLIT: begin
                    rsp_rdata_r <= we_r ? 32'h0000_0000
                                        : load_ext(32'({rd_s, lo_r} >> sh_s), ctrl_r);
                end
`endif
                default: begin
                    rsp_rdata_r <= rsp_rdata_r;
                end
            endcase
        end
    end

    assign req_ready = (state_r == IDLE);
    assign rsp_valid = (state_r == RESP);
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed, table-driven bench for data_memory_ctrl plus hand-written sequences for
// backpressure and reset in the middle of an access.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

`ifdef DMEM_SPLIT_ACCESS_EN
    localparam logic       XE = 1'b0;
    localparam int         XL = 3;
    localparam logic [31:0] X_LW10 = 32'h4455BEEF, X_LW14 = 32'h00112233;
    localparam logic [31:0] X_LW11 = 32'h334455BE, X_LH13 = 32'h00003344;
`else
    localparam logic       XE = 1'b1;
    localparam int         XL = 2;
    localparam logic [31:0] X_LW10 = 32'hDE55BEEF, X_LW14 = 32'h00000000;
    localparam logic [31:0] X_LW11 = 32'h00000000, X_LH13 = 32'h00000000;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt[$];

    data_memory_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] e, input logic er, input int l);
        vec_t v;
        v.we = we; v.ctrl = c; v.addr = a; v.wd = wd;
        v.exp_rd = e; v.exp_err = er; v.exp_lat = l;
        vt.push_back(v);
    endtask

    // Present a request, wait for the response, optionally hold it for `hold` cycles.
    task automatic xfer(input logic we, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic rr);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_ctrl = c; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 11;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        rd = rsp_rdata; er = rsp_err; rr = req_ready;
        if (lat <= 10) begin
            for (int i = 0; i < hold; i++) begin
                check($sformatf("hold%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
                check($sformatf("hold%0d_rdata", i), rsp_rdata, exp_rd);
                check($sformatf("hold%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    // Accept a request and return just after the accept edge.
    task automatic start_req(input logic we, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_ctrl = c; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic check_cleared(input string nm);
        check({nm, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check({nm, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({nm, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
    endtask

    task automatic simple(input string nm, input logic we, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e);
        logic [31:0] rd; logic er, rr; int lat;
        xfer(we, c, a, wd, 0, 32'h0, rd, er, lat, rr);
        check({nm, "_rdata"}, rd, e);
        check({nm, "_err"}, {31'b0, er}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd; logic er, rr; int lat;

        add(1'b1, W,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2);
        add(1'b0, W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2);
        add(1'b0, B,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2);
        add(1'b0, BU, 32'h13,   32'h0,        32'h000000DE, 1'b0, 2);
        add(1'b0, H,  32'h11,   32'h0,        32'hFFFFADBE, 1'b0, 2);
        add(1'b0, HU, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 2);
        add(1'b0, B,  32'h10,   32'h0,        32'hFFFFFFEF, 1'b0, 2);
        add(1'b1, B,  32'h12,   32'hFFFFFF55, 32'h0,        1'b0, 2);
        add(1'b0, W,  32'h10,   32'h0,        32'hDE55BEEF, 1'b0, 2);
        add(1'b1, W,  32'h18,   32'h0,        32'h0,        1'b0, 2);
        add(1'b1, H,  32'h1A,   32'hFFFF8001, 32'h0,        1'b0, 2);
        add(1'b0, W,  32'h18,   32'h0,        32'h80010000, 1'b0, 2);
        add(1'b0, H,  32'h1A,   32'h0,        32'hFFFF8001, 1'b0, 2);
        add(1'b0, HU, 32'h1A,   32'h0,        32'h00008001, 1'b0, 2);
        add(1'b0, B,  32'h1B,   32'h0,        32'hFFFFFF80, 1'b0, 2);
        add(1'b0, W,  32'h2000, 32'h0,        32'h0,        1'b1, 2);
        add(1'b0, 3'b011, 32'h10, 32'h0,      32'h0,        1'b1, 2);
        add(1'b0, 3'b110, 32'h10, 32'h0,      32'h0,        1'b1, 2);
        add(1'b0, 3'b111, 32'h10, 32'h0,      32'h0,        1'b1, 2);
        add(1'b1, BU, 32'h10,   32'h12345678, 32'h0,        1'b1, 2);
        add(1'b1, HU, 32'h10,   32'h12345678, 32'h0,        1'b1, 2);
        add(1'b0, W,  32'h10,   32'h0,        32'hDE55BEEF, 1'b0, 2);
        add(1'b1, W,  32'h1FFC, 32'hA5A50F0F, 32'h0,        1'b0, 2);
        add(1'b0, W,  32'h1FFC, 32'h0,        32'hA5A50F0F, 1'b0, 2);
        add(1'b0, H,  32'h1FFF, 32'h0,        32'h0,        1'b1, 2);
        add(1'b1, W,  32'h1FFE, 32'h0,        32'h0,        1'b1, 2);
        add(1'b0, W,  32'h1FFC, 32'h0,        32'hA5A50F0F, 1'b0, 2);
        add(1'b1, W,  32'h14,   32'h0,        32'h0,        1'b0, 2);
        add(1'b1, W,  32'h13,   32'h11223344, 32'h0,        XE,   XL);
        add(1'b0, W,  32'h10,   32'h0,        X_LW10,       1'b0, 2);
        add(1'b0, W,  32'h14,   32'h0,        X_LW14,       1'b0, 2);
        add(1'b0, W,  32'h11,   32'h0,        X_LW11,       XE,   XL);
        add(1'b0, H,  32'h13,   32'h0,        X_LH13,       XE,   XL);

        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        foreach (vt[i]) begin
            xfer(vt[i].we, vt[i].ctrl, vt[i].addr, vt[i].wd, 0, 32'h0, rd, er, lat, rr);
            check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            check($sformatf("v%0d_req_ready_in_resp", i), {31'b0, rr}, 32'd0);
        end

        // Backpressure: response held for five cycles.
        xfer(1'b0, W, 32'h18, 32'h0, 5, 32'h80010000, rd, er, lat, rr);
        check("bp_rdata", rd, 32'h80010000);

        // Reset during ACCESS of a store: nothing commits.
        simple("pre_acc", 1'b1, W, 32'h20, 32'h01020304, 32'h0);
        start_req(1'b1, W, 32'h20, 32'hCAFEF00D);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_access");
        @(negedge clk);
        rst_n = 1'b1;
        simple("post_acc", 1'b0, W, 32'h20, 32'h0, 32'h01020304);

`ifdef DMEM_SPLIT_ACCESS_EN
        // Reset during SPLIT: lower word keeps its new bytes, upper word untouched.
        simple("pre_sp0", 1'b1, W, 32'h24, 32'h11111111, 32'h0);
        simple("pre_sp1", 1'b1, W, 32'h28, 32'h22222222, 32'h0);
        start_req(1'b1, W, 32'h26, 32'hAABBCCDD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_split");
        @(negedge clk);
        rst_n = 1'b1;
        simple("post_sp0", 1'b0, W, 32'h24, 32'h0, 32'hCCDD1111);
        simple("post_sp1", 1'b0, W, 32'h28, 32'h0, 32'h22222222);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
